alu_exec_unit: RTL and testbench

Execute stage of the single-cycle MIPS-subset datapath. It combines three functions:
- ALU-control decode of the main-control ALUOp bits and the instruction funct field.
- A 32-bit ALU with a zero flag.
- The two 32-bit address adders: PC+4, and branch target = PC+4 + (offset<<2).

A clocked, resettable result register gives downstream pipelining and observation logic a registered copy of the ALU outputs.

---
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute stage of the single-cycle MIPS-subset datapath:
//   * ALU-control decode of the main-control aluop bits and the funct field
//   * 32-bit ALU with zero flag
//   * PC+4 adder and branch-target adder (pc_plus4 + offset<<2)
//   * registered copy of the ALU result and zero flag
//
// Optional feature macro: ALU_NOR_EN
//   defined   : aluop=10 / funct=0111 decodes to nor (gout=100), ALU gives ~(a|b)
//   undefined : funct=0111 decodes to add, and gout=100 gives sum=0
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset (result register only)
//   en             in   1   load enable for the result register
//   aluop          in   2   {aluop1, aluop0} from main control
//   funct          in   4   instruction bits [3:0]
//   a              in  32   operand A
//   b              in  32   operand B
//   pc             in  32   current program counter
//   imm_ext        in  32   sign-extended 16-bit offset
//   gout           out  3   decoded ALU operation (combinational)
//   sum            out 32   ALU result (combinational)
//   zout           out  1   sum == 0 (combinational)
//   pc_plus4       out 32   pc + 4 (combinational)
//   branch_target  out 32   pc_plus4 + {imm_ext[29:0], 2'b00} (combinational)
//   sum_q          out 32   registered sum
//   zout_q         out  1   registered zout
// ---------------------------------------------------------------------------
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  aluop,
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    output logic [2:0]  gout,
    output logic [31:0] sum,
    output logic        zout,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] sum_q,
    output logic        zout_q
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // -----------------------------------------------------------------------
    // ALU control decode (first match wins)
    // -----------------------------------------------------------------------
    always_comb begin
        gout = OP_ADD;
        if (aluop == 2'b00) begin
            gout = OP_ADD;
        end else if (aluop[0]) begin
            gout = OP_SUB;
        end else begin
            unique case (funct)
                4'b0000: gout = OP_ADD;
                4'b0010: gout = OP_SUB;
                4'b0100: gout = OP_AND;
                4'b0101: gout = OP_OR;
                4'b1010: gout = OP_SLT;
`ifdef ALU_NOR_EN
                4'b0111: gout = OP_NOR;
`endif
                default: gout = OP_ADD;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Bitwise logic, one slice per bit
    // -----------------------------------------------------------------------
    logic [31:0] and_bits;
    logic [31:0] or_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_logic
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Shared adder: subtract and slt both use a + ~b + 1
    // -----------------------------------------------------------------------
    logic        use_sub;
    logic [31:0] b_operand;
    logic [31:0] add_res;
    logic        slt_bit;

    assign use_sub   = (gout == OP_SUB) || (gout == OP_SLT);
    assign b_operand = use_sub ? ~b : b;
    assign add_res   = a + b_operand + {31'd0, use_sub};

    // When signs differ the difference may overflow, but the answer is then
    // simply "a is the negative one"; otherwise the difference sign is exact.
    assign slt_bit = (a[31] != b[31]) ? a[31] : add_res[31];

    always_comb begin
        sum = 32'd0;
        unique case (gout)
            OP_AND:  sum = and_bits;
            OP_OR:   sum = or_bits;
            OP_ADD:  sum = add_res;
            OP_SUB:  sum = add_res;
            OP_SLT:  sum = {31'd0, slt_bit};
`ifdef ALU_NOR_EN
            OP_NOR:  sum = ~or_bits;
`endif
            default: sum = 32'd0;
        endcase
    end

    assign zout = ~|sum;

    // -----------------------------------------------------------------------
    // Address adders (wrap modulo 2^32; offset drops imm_ext[31:30])
    // -----------------------------------------------------------------------
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

    // -----------------------------------------------------------------------
    // Result register
    // -----------------------------------------------------------------------
    logic [31:0] sum_reg;
    logic        zout_reg;
    logic [31:0] sum_next;
    logic        zout_next;

    always_comb begin
        sum_next  = sum_reg;
        zout_next = zout_reg;
        if (en) begin
            sum_next  = sum;
            zout_next = zout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= 32'd0;
            zout_reg <= 1'b0;
        end else begin
            sum_reg  <= sum_next;
            zout_reg <= zout_next;
        end
    end

    assign sum_q  = sum_reg;
    assign zout_q = zout_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed-vector bench for alu_exec_unit. Expected values are hand-computed
// constants. Build with +define+ALU_NOR_EN to exercise the nor build.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [2:0]  gout;
    logic [31:0] sum;
    logic        zout;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] sum_q;
    logic        zout_q;

    int n_checks;
    int n_fail;

    alu_exec_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .aluop         (aluop),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .pc            (pc),
        .imm_ext       (imm_ext),
        .gout          (gout),
        .sum           (sum),
        .zout          (zout),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .sum_q         (sum_q),
        .zout_q        (zout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Apply one ALU vector and check the three combinational ALU outputs.
    task automatic alu_vec(input string tag, input logic [1:0] op, input logic [3:0] fn,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [2:0] exp_g, input logic [31:0] exp_s,
                           input logic exp_z);
        @(negedge clk);
        aluop = op;
        funct = fn;
        a     = va;
        b     = vb;
        #1;
        check({tag, ".gout"}, {29'd0, gout}, {29'd0, exp_g});
        check({tag, ".sum"},  sum,           exp_s);
        check({tag, ".zout"}, {31'd0, zout}, {31'd0, exp_z});
    endtask

    task automatic reg_step(input string tag, input logic [31:0] exp_s, input logic exp_z);
        @(posedge clk);
        #1;
        check({tag, ".sum_q"},  sum_q,           exp_s);
        check({tag, ".zout_q"}, {31'd0, zout_q}, {31'd0, exp_z});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        aluop    = 2'b00;
        funct    = 4'b0000;
        a        = 32'd0;
        b        = 32'd0;
        pc       = 32'd0;
        imm_ext  = 32'd0;

        // Reset state (asynchronous assertion before any clock edge)
        #2 rst_n = 1'b0;
        #1;
        check("reset.sum_q",  sum_q,           32'd0);
        check("reset.zout_q", {31'd0, zout_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic decode
        alu_vec("lw_add",  2'b00, 4'b1111, 32'h10, 32'h4, 3'b010, 32'h14, 1'b0);
        alu_vec("beq_sub", 2'b01, 4'b0000, 32'h7,  32'h7, 3'b110, 32'h0,  1'b1);
        alu_vec("beq_x1",  2'b11, 4'b0100, 32'h9,  32'h7, 3'b110, 32'h2,  1'b0);

        // R-type sweep
        alu_vec("r_add", 2'b10, 4'b0000, 32'hF0F0_0000, 32'h0FF0_0001, 3'b010, 32'h00E0_0001, 1'b0);
        alu_vec("r_sub", 2'b10, 4'b0010, 32'hF0F0_0000, 32'h0FF0_0001, 3'b110, 32'hE0FF_FFFF, 1'b0);
        alu_vec("r_and", 2'b10, 4'b0100, 32'hF0F0_0000, 32'h0FF0_0001, 3'b000, 32'h00F0_0000, 1'b0);
        alu_vec("r_or",  2'b10, 4'b0101, 32'hF0F0_0000, 32'h0FF0_0001, 3'b001, 32'hFFF0_0001, 1'b0);
        alu_vec("r_slt", 2'b10, 4'b1010, 32'hF0F0_0000, 32'h0FF0_0001, 3'b111, 32'h1,         1'b0);
        alu_vec("r_dflt", 2'b10, 4'b0011, 32'h5, 32'h6, 3'b010, 32'hB, 1'b0);

        // slt sign boundaries
        alu_vec("slt_neg_pos", 2'b10, 4'b1010, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h1, 1'b0);
        alu_vec("slt_pos_neg", 2'b10, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0, 1'b1);
        alu_vec("slt_equal",   2'b10, 4'b1010, 32'h1234_5678, 32'h1234_5678, 3'b111, 32'h0, 1'b1);
        alu_vec("slt_neg_neg", 2'b10, 4'b1010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b111, 32'h1, 1'b0);

        // Wrap
        alu_vec("add_wrap", 2'b10, 4'b0000, 32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1'b1);

        // funct 0111
`ifdef ALU_NOR_EN
        alu_vec("nor", 2'b10, 4'b0111, 32'h0, 32'h0, 3'b100, 32'hFFFF_FFFF, 1'b0);
`else
        alu_vec("f0111_add", 2'b10, 4'b0111, 32'h0, 32'h0, 3'b010, 32'h0, 1'b1);
`endif

        // Address adders
        @(negedge clk);
        pc = 32'hFFFF_FFFC;
        imm_ext = 32'd0;
        #1;
        check("pc4_wrap", pc_plus4, 32'h0);
        pc = 32'h8;
        imm_ext = 32'hFFFF_FFFE;
        #1;
        check("pc4", pc_plus4, 32'hC);
        check("btarget_neg", branch_target, 32'h4);
        pc = 32'h100;
        imm_ext = 32'h4000_0003;   // bits [31:30] dropped by the shift
        #1;
        check("btarget_drop", branch_target, 32'h110);

        // Result register: load, hold, load zero result
        alu_vec("reg_op", 2'b00, 4'b0000, 32'h10, 32'h4, 3'b010, 32'h14, 1'b0);
        en = 1'b1;
        reg_step("load14", 32'h14, 1'b0);
        alu_vec("reg_op2", 2'b01, 4'b0000, 32'h7, 32'h7, 3'b110, 32'h0, 1'b1);
        en = 1'b0;
        reg_step("hold", 32'h14, 1'b0);

        // Asynchronous reset mid-cycle clears sum_q
        #2 rst_n = 1'b0;
        #1;
        check("arst1.sum_q", sum_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        reg_step("loadz", 32'h0, 1'b1);

        // Asynchronous reset mid-cycle clears zout_q
        #2 rst_n = 1'b0;
        #1;
        check("arst2.zout_q", {31'd0, zout_q}, 32'h0);

        // Reset wins over en at a clock edge
        alu_vec("reg_op3", 2'b00, 4'b0000, 32'h10, 32'h4, 3'b010, 32'h14, 1'b0);
        en = 1'b1;
        reg_step("rst_wins", 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        reg_step("after_rst", 32'h14, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
